// File: rtl/noc_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// noc_rr_arbiter_pkg
//   Shared definitions for the router output-port round-robin arbiter:
//   default sizing constants, the clog2 constant function and the
//   arbiter state type. The ARB_MAXHOLD_EN macro is left undefined here,
//   so the starvation guard is off unless the build defines it.
// ----------------------------------------------------------------------------
package noc_rr_arbiter_pkg;

   localparam int ARB_N_DEF        = 5;
   localparam int ARB_IDW_DEF      = 3;
   localparam int ARB_MAX_HOLD_DEF = 16;

   // Ceiling log2, for sizing index and counter fields at elaboration.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// noc_rr_arbiter_if
//   Request/grant bundle between the requesters of one output port and
//   its arbiter.
//   req      N    request vector, held high for the whole packet
//   gnt      N    one-hot grant, all zero when idle
//   gnt_vld  1    |gnt
//   gnt_id   IDW  binary index of the granted requester, 0 when idle
//   Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface noc_rr_arbiter_if
   import noc_rr_arbiter_pkg::*;
#(
   parameter int N   = ARB_N_DEF,
   parameter int IDW = ARB_IDW_DEF
) ();

   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;

   modport master (output req, input  gnt, input  gnt_vld, input  gnt_id);
   modport slave  (input  req, output gnt, output gnt_vld, output gnt_id);

endinterface

// File: rtl/noc_rr_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_prio_pick
//   Combinational rotating-priority picker. Scans req starting at index
//   ptr, ascending and wrapping, and returns the first set bit.
//   req     in   N    request vector
//   ptr     in   IDW  highest-priority index
//   onehot  out  N    winning requester, one-hot (zero if none)
//   id      out  IDW  winning index (zero if none)
//   any     out  1    at least one request present
// ----------------------------------------------------------------------------
module rr_prio_pick
   import noc_rr_arbiter_pkg::*;
#(
   parameter int N   = ARB_N_DEF,
   parameter int IDW = ARB_IDW_DEF
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   onehot,
   output logic [IDW-1:0] id,
   output logic           any
);

   logic [2*N-1:0] dbl;
   logic           found;

   // The lower copy keeps only requests at or above ptr; the upper copy is
   // the full vector. A plain lowest-bit search over the concatenation then
   // yields the wrapped scan without any rotate logic.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise paths that skip an assignment infer latches.
      dbl    = '0;
      onehot = '0;
      id     = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         dbl[i]     = req[i] & (i >= int'(ptr));
         dbl[i + N] = req[i];
      end
      for (int i = 0; i < 2*N; i++) begin
         if (!found && dbl[i]) begin
            found           = 1'b1;
            onehot[i % N]   = 1'b1;
            id              = IDW'(i % N);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/noc_rr_arbiter.sv
// ----------------------------------------------------------------------------
// noc_rr_arbiter
//   N-input round-robin arbiter with grant lock for one router output port.
//   A granted requester keeps the grant while its req stays high; when it
//   drops, the next requester from the rotating pointer takes over on the
//   same edge. All outputs are registered (one cycle req->gnt latency).
//   Optional macro ARB_MAXHOLD_EN adds a max-hold starvation guard: after
//   MAX_HOLD consecutive cycles with other requests pending, the grant is
//   forced to rotate.
//   clk   in  1       clock, rising edge
//   rst   in  1       asynchronous active-high reset
//   arb   slave       req in; gnt / gnt_vld / gnt_id out
// ----------------------------------------------------------------------------
module noc_rr_arbiter
   import noc_rr_arbiter_pkg::*;
#(
   parameter int N        = ARB_N_DEF,
   parameter int IDW      = ARB_IDW_DEF,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
   input logic             clk,
   input logic             rst,
   noc_rr_arbiter_if.slave arb
);

   arb_state_e     st;
   logic [N-1:0]   gnt_q;
   logic [IDW-1:0] gnt_id_q;
   logic [IDW-1:0] ptr;

   logic [N-1:0]   pick_onehot;
   logic [IDW-1:0] pick_id;
   logic           pick_any;
   logic [IDW-1:0] ptr_nxt;
   logic           holder_req;
   logic           expire;
   logic           keep;

   rr_prio_pick #(.N(N), .IDW(IDW)) u_pick (
      .req    (arb.req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .id     (pick_id),
      .any    (pick_any)
   );

   // The winner drops to lowest priority for the next arbitration.
   assign ptr_nxt    = (pick_id == IDW'(N-1)) ? '0 : pick_id + IDW'(1);

   // gnt_q is zero when idle, so this is also false in ST_IDLE.
   assign holder_req = |(arb.req & gnt_q);

`ifdef ARB_MAXHOLD_EN
   localparam int HCW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);

   logic [HCW-1:0] hold_cnt;

   // hold_cnt saturates at MAX_HOLD-1, so the guard still fires when a
   // competitor shows up after a long uncontended hold.
   assign expire = (hold_cnt == HCW'(MAX_HOLD-1)) && |(arb.req & ~gnt_q);
`else
   assign expire = 1'b0;
`endif

   assign keep = holder_req && !expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every state flop is reset here; state updates use
         // non-blocking assignments so all flops see pre-edge values.
         st       <= ST_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr      <= '0;
`ifdef ARB_MAXHOLD_EN
         hold_cnt <= '0;
`endif
      end else begin
         if (keep) begin
            // Lock: the holder keeps the grant; the pointer already sits
            // one past it from the original grant.
            st <= ST_BUSY;
`ifdef ARB_MAXHOLD_EN
            if (hold_cnt != HCW'(MAX_HOLD-1)) hold_cnt <= hold_cnt + HCW'(1);
`endif
         end else if (pick_any) begin
            // Fresh grant from idle, handover on holder release, or forced
            // rotation; all take effect on this edge with no bubble.
            st       <= ST_BUSY;
            gnt_q    <= pick_onehot;
            gnt_id_q <= pick_id;
            ptr      <= ptr_nxt;
`ifdef ARB_MAXHOLD_EN
            hold_cnt <= '0;
`endif
         end else begin
            st       <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
`ifdef ARB_MAXHOLD_EN
            hold_cnt <= '0;
`endif
         end
      end
   end

   assign arb.gnt     = gnt_q;
   assign arb.gnt_vld = (st == ST_BUSY);
   assign arb.gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_noc_rr_arbiter
//   Bench for noc_rr_arbiter with N=5, MAX_HOLD=4. Directed cases with
//   literal expectations, then random request traffic compared every cycle
//   against a behavioural round-robin model.
// ----------------------------------------------------------------------------
module tb_noc_rr_arbiter;
   import noc_rr_arbiter_pkg::*;

   localparam int N        = 5;
   localparam int IDW      = 3;
   localparam int MAX_HOLD = 4;
`ifdef ARB_MAXHOLD_EN
   localparam bit MH = 1'b1;
`else
   localparam bit MH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   noc_rr_arbiter_if #(.N(N), .IDW(IDW)) arb ();

   noc_rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int           m_id   = -1;   // granted requester, -1 when idle
   int           m_ptr  = 0;    // first index scanned next time
   int           m_held = 0;    // cycles the current grant has lasted
   logic [N-1:0] s_req  = '0;   // request vector seen at the last edge

   function automatic int rr_pick(input logic [N-1:0] r, input int from);
      for (int off = 0; off < N; off++)
         if (r[(from + off) % N]) return (from + off) % N;
      return -1;
   endfunction

   function automatic bit others_req(input logic [N-1:0] r, input int k);
      logic [N-1:0] m;
      m = r;
      m[k] = 1'b0;
      return m != '0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_id   <= -1;
         m_ptr  <= 0;
         m_held <= 0;
         s_req  <= '0;
      end else begin
         s_req <= arb.req;
         if (m_id >= 0 && arb.req[m_id] &&
             !(MH && others_req(arb.req, m_id) && m_held >= MAX_HOLD)) begin
            m_held <= m_held + 1;
         end else if (rr_pick(arb.req, m_ptr) >= 0) begin
            m_id   <= rr_pick(arb.req, m_ptr);
            m_ptr  <= (rr_pick(arb.req, m_ptr) + 1) % N;
            m_held <= 1;
         end else begin
            m_id   <= -1;
            m_held <= 0;
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   int wait_cnt [N];

   always @(negedge clk) begin
      check("gnt",     32'(arb.gnt),     (m_id >= 0) ? (32'd1 << m_id) : 32'd0);
      check("gnt_vld", 32'(arb.gnt_vld), (m_id >= 0) ? 32'd1 : 32'd0);
      check("gnt_id",  32'(arb.gnt_id),  (m_id >= 0) ? 32'(m_id) : 32'd0);
      check("onehot",  32'($countones(arb.gnt) <= 1), 32'd1);
      check("vld_eq_or", 32'(arb.gnt_vld), 32'(|arb.gnt));
      if (|arb.gnt) check("gnt_without_req", 32'(|(arb.gnt & s_req)), 32'd1);
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            wait_cnt[i] <= 0;
         end else if (arb.req[i] && !arb.gnt[i]) begin
            wait_cnt[i] <= wait_cnt[i] + 1;
         end else begin
            if (MH && arb.gnt[i] && wait_cnt[i] > 0)
               check("wait_bound", 32'(wait_cnt[i] <= (N-1)*MAX_HOLD + 1), 32'd1);
            wait_cnt[i] <= 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [N-1:0] r);
      arb.req = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1);
   end

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] lvl;
      int           remain [N];
      int           fair_exp [6] = '{0, 1, 2, 3, 4, 0};
      int           exp_id;
      logic [N-1:0] exp_g;

      arb.req = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",     32'(arb.gnt),     32'd0);
      check("rst_gnt_vld", 32'(arb.gnt_vld), 32'd0);
      check("rst_gnt_id",  32'(arb.gnt_id),  32'd0);
      rst = 1'b0;

      // Reset mid-packet removes the grant without waiting for a clock.
      cyc('1);
      check("pre_rst_vld", 32'(arb.gnt_vld), 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_gnt",     32'(arb.gnt),     32'd0);
      check("async_rst_gnt_vld", 32'(arb.gnt_vld), 32'd0);
      check("async_rst_gnt_id",  32'(arb.gnt_id),  32'd0);
      arb.req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fairness: all request, the holder pulses low for one cycle.
      for (int i = 0; i < 6; i++) begin
         r = '1;
         if (i > 0) r[fair_exp[i-1]] = 1'b0;
         cyc(r);
         check("fair_id",  32'(arb.gnt_id),  32'(fair_exp[i]));
         check("fair_vld", 32'(arb.gnt_vld), 32'd1);
      end

      // Lock and handover: req0 for 6 cycles, req3 joins from cycle 2.
      cyc('0);
      check("idle_gap", 32'(arb.gnt), 32'd0);
      for (int c = 0; c < 6; c++) begin
         r = (c >= 2) ? 5'b01001 : 5'b00001;
         cyc(r);
         exp_g = (MH && c >= 4) ? 5'b01000 : 5'b00001;
         check("lock_gnt", 32'(arb.gnt), 32'(exp_g));
      end
      cyc(5'b01000);
      check("handover_gnt", 32'(arb.gnt), 32'h08);

      // Wrap and idle.
      cyc(5'b10000);
      check("wrap_id4", 32'(arb.gnt_id), 32'd4);
      for (int c = 0; c < 3; c++) begin
         cyc('0);
         check("idle_gnt", 32'(arb.gnt), 32'd0);
         check("idle_vld", 32'(arb.gnt_vld), 32'd0);
      end
      cyc(5'b10001);
      check("wrap_id0", 32'(arb.gnt_id), 32'd0);

      // Two continuous requesters: lock forever, or rotation every MAX_HOLD.
      cyc('0);
      for (int c = 0; c < 12; c++) begin
         cyc(5'b00110);
         exp_id = (MH && ((c / MAX_HOLD) % 2 == 1)) ? 2 : 1;
         check("hold_id", 32'(arb.gnt_id), 32'(exp_id));
      end
      cyc('0);

      // Random traffic: packet-like levels, then raw random vectors.
      lvl = '0;
      for (int i = 0; i < N; i++) remain[i] = 0;
      for (int t = 0; t < 10000; t++) begin
         if (t < 5000) begin
            for (int i = 0; i < N; i++) begin
               if (remain[i] == 0) begin
                  lvl[i]    = ~lvl[i];
                  remain[i] = lvl[i] ? int'($urandom_range(12, 1)) : int'($urandom_range(4, 1));
               end
               remain[i] = remain[i] - 1;
            end
            r = lvl;
         end else begin
            r = N'($urandom);
         end
         cyc(r);
      end
      cyc('0);
      cyc('0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
